multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle RV32I control unit: a Moore/Mealy FSM that sequences FETCH/DECODE/EXEC/MEM/WB
//  per instruction and drives datapath enables plus a req/ack handshake to instruction and data memory.
//  Generalises the single-cycle control decode: adds unsigned loads, jal/jalr, stall on memory wait
//  and a bus-timeout watchdog. Sits between the instruction register and the shared datapath.
// PARAMETERS
//  TO_W     4    width of memory-wait watchdog counter
//  TO_MAX   15   cycles a req may stay un-acked before bus_err (must be <= 2**TO_W-1, >=1)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  instr      in   32 instruction register contents (valid from DECODE onward)
//  br_taken   in   1  branch comparator result, valid in EXEC
//  imem_ack   in   1  instruction memory data valid
//  dmem_ack   in   1  data memory access complete
//  imem_req   out  1  instruction fetch request, held until imem_ack
//  dmem_req   out  1  data access request, held until dmem_ack
//  dmem_we    out  1  store when 1 (qualified by dmem_req)
//  mem_size   out  2  00 byte, 01 half, 10 word (from func3[1:0])
//  mem_uns    out  1  zero-extend load (func3[2])
//  ir_we      out  1  latch instruction register
//  pc_we      out  1  update PC
//  pc_src     out  2  00 pc+4, 01 pc+imm (branch/jal), 10 ALU result & ~1 (jalr)
//  rwen       out  1  register-file write enable
//  memreg     out  2  WB mux: 00 ALU, 01 load data, 10 imm (lui), 11 pc+4 (jal/jalr)
//  ALUsrcA    out  1  0 rs1, 1 pc
//  ALUsrc     out  2  00 rs2, 01 imm, 10 imm (auipc)
//  ALUop      out  2  00 add, 01 sub/compare, 10 R-type func, 11 I-type func
//  immsel     out  3  000 I, 001 S, 010 B, 011 U, 100 J
//  bus_err    out  1  sticky watchdog error
//  state_o    out  3  current state for debug
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Reset -> FETCH; all outputs 0 except
//    imem_req=1 combinationally once out of reset (FETCH decode).
//  - FETCH: imem_req=1; on imem_ack: ir_we=1, -> DECODE. No ack: stay.
//  - DECODE: one cycle, decode opcode/func3 into registered controls; -> EXEC.
//  - EXEC: R/I/lui/auipc/jal/jalr -> WB. load/store -> MEM. branch: pc_we=br_taken, pc_src=01,
//    -> FETCH; not-taken branch pc_we=1 pc_src=00. Other opcode: see ILLEGAL_TRAP_EN.
//  - MEM: dmem_req=1, dmem_we=store; size/uns from func3. On dmem_ack: load -> WB; store: pc_we=1,
//    pc_src=00, -> FETCH. Load func3 3'b011/110/111 treated as word.
//  - WB: rwen=1 (except rd==0 -> 0), pc_we=1, pc_src per opcode; -> FETCH. Exactly one cycle.
//  - CPI: ALU 4 + fetch wait; load 5 + waits; store 4 + waits; branch 3 + fetch wait.
//  - Watchdog: counter clears on entering FETCH/MEM and on ack; increments each cycle req
//    is high without ack; at count==TO_MAX with no ack: bus_err<=1, -> HALT. Ack on the same cycle
//    the count reaches TO_MAX wins (no error).
//  - HALT: all enables/reqs 0; leave only on rst_n. bus_err cleared only by reset.
//  - Reset asserted mid-instruction: immediate return to FETCH, counter 0, no partial write.
//  - rwen, pc_we, ir_we, dmem_req are never high in the same cycle as each other except rwen+pc_we.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode in EXEC -> HALT, illegal pulses 1 for one cycle
//    (extra 1-bit output port illegal, reset 0).
//  Undefined: unknown opcode executes as NOP: EXEC -> WB with rwen=0, pc_we=1, pc_src=00.
// TESTING
//  add x3,x1,x2, imem_ack on 1st cycle -> states 0,1,2,4,0; rwen=1 in WB, memreg=00, ALUop=10.
//  lhu x5,4(x1), dmem_ack after 3 wait cycles -> MEM held 4 cycles, mem_size=01, mem_uns=1, memreg=01.
//  beq taken (br_taken=1) -> pc_we=1, pc_src=01, rwen never 1; not taken -> pc_src=00.
//  jalr x1,0(x2) -> WB: rwen=1, memreg=11, pc_src=10; sw -> dmem_we=1, mem_size=10, no rwen.
//  imem_ack withheld TO_MAX=15 cycles -> bus_err=1, state HALT; ack on 15th cycle -> no error.
//  opcode 7'b1111111: with ILLEGAL_TRAP_EN -> HALT, illegal 1-cycle; without -> NOP, pc_we=1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory watchdog.
// Optional ILLEGAL_TRAP_EN: unknown opcodes halt and pulse the extra 'illegal' output.
module multicycle_ctrl_fsm #(
    parameter int TO_W   = 4,
    parameter int TO_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  mem_size,
    output logic        mem_uns,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rwen,
    output logic [1:0]  memreg,
    output logic        ALUsrcA,
    output logic [1:0]  ALUsrc,
    output logic [1:0]  ALUop,
    output logic [2:0]  immsel,
    output logic        bus_err,
`ifdef ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [2:0]  state_o
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_R, C_I, C_LOAD, C_STORE, C_BR, C_LUI, C_AUIPC, C_JAL, C_JALR
    } cls_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_MAX - 1);

    state_t          state_q;
    cls_t            cls_q, cls_d;
    logic [1:0]      msize_q, msize_d;
    logic            muns_q, muns_d;
    logic            rdz_q;
    logic [TO_W-1:0] wd_q;
    logic            bus_err_q;
`ifdef ILLEGAL_TRAP_EN
    logic            illegal_q;
`endif
    logic            unused_instr;

    assign unused_instr = ^instr[31:15];

    always_comb begin
        cls_d = C_ILL;
        case (instr[6:0])
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_I;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            7'b1100011: cls_d = C_BR;
            7'b0110111: cls_d = C_LUI;
            7'b0010111: cls_d = C_AUIPC;
            7'b1101111: cls_d = C_JAL;
            7'b1100111: cls_d = C_JALR;
            default:    cls_d = C_ILL;
        endcase
        // func3 size 2'b11 has no RV32 meaning; it and its unsigned forms collapse to a word access
        msize_d = (instr[13:12] == 2'b11) ? 2'b10 : instr[13:12];
        muns_d  = instr[14] && !instr[13] && (cls_d == C_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            msize_q   <= 2'b00;
            muns_q    <= 1'b0;
            rdz_q     <= 1'b0;
            wd_q      <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        state_q <= S_DECODE;
                        wd_q    <= '0;
                    end else if (wd_q == WD_LAST) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    cls_q   <= cls_d;
                    msize_q <= msize_d;
                    muns_q  <= muns_d;
                    rdz_q   <= (instr[11:7] == 5'd0);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LOAD, C_STORE: begin
                            state_q <= S_MEM;
                            wd_q    <= '0;
                        end
                        C_BR: begin
                            state_q <= S_FETCH;
                            wd_q    <= '0;
                        end
`ifdef ILLEGAL_TRAP_EN
                        C_ILL: begin
                            state_q   <= S_HALT;
                            illegal_q <= 1'b1;
                        end
`endif
                        default: state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state_q <= (cls_q == C_LOAD) ? S_WB : S_FETCH;
                        wd_q    <= '0;
                    end else if (wd_q == WD_LAST) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    wd_q    <= '0;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        mem_size = 2'b00;
        mem_uns  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'b00;
        rwen     = 1'b0;
        memreg   = 2'b00;
        ALUsrcA  = 1'b0;
        ALUsrc   = 2'b00;
        ALUop    = 2'b00;
        immsel   = 3'b000;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (cls_q)
                C_R:     ALUop = 2'b10;
                C_I:     begin ALUop = 2'b11; ALUsrc = 2'b01; end
                C_LOAD:  begin ALUsrc = 2'b01; memreg = 2'b01; end
                C_STORE: begin ALUsrc = 2'b01; immsel = 3'b001; end
                C_BR:    begin ALUop = 2'b01; immsel = 3'b010; end
                C_LUI:   begin ALUsrc = 2'b01; immsel = 3'b011; memreg = 2'b10; end
                C_AUIPC: begin ALUsrcA = 1'b1; ALUsrc = 2'b10; immsel = 3'b011; end
                C_JAL:   begin ALUsrcA = 1'b1; ALUsrc = 2'b01; immsel = 3'b100; memreg = 2'b11; end
                C_JALR:  begin ALUsrc = 2'b01; memreg = 2'b11; end
                default: ;
            endcase
        end
        case (state_q)
            S_FETCH: begin
                imem_req = rst_n;
                ir_we    = rst_n && imem_ack;
            end
            S_EXEC: begin
                if (cls_q == C_BR) begin
                    pc_we  = 1'b1;
                    pc_src = br_taken ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                // A store retires on its ack cycle; dropping req there keeps pc_we and dmem_req exclusive
                dmem_req = !((cls_q == C_STORE) && dmem_ack);
                dmem_we  = (cls_q == C_STORE) && !dmem_ack;
                mem_size = msize_q;
                mem_uns  = muns_q;
                pc_we    = (cls_q == C_STORE) && dmem_ack;
            end
            S_WB: begin
                rwen  = !rdz_q && (cls_q != C_ILL);
                pc_we = 1'b1;
                if (cls_q == C_JAL)       pc_src = 2'b01;
                else if (cls_q == C_JALR) pc_src = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus_err = bus_err_q;
    assign state_o = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`endif
endmodule
